// File: rtl/mem_wb_writeback_if.sv
// MEM/WB stage bundle: MEM-stage control and result fields in, register-file
// write port, forwarding tap and retire statistics out.
interface mem_wb_writeback_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
);
  logic              Stall;
  logic              Flush;
  logic              InValid;
  logic              InRegWrite;
  logic [4:0]        InWriteReg;
  logic [1:0]        InResultSel;
  logic [2:0]        InLoadType;
  logic [1:0]        InAddrLow;
  logic [DATA_W-1:0] InAluResult;
  logic [DATA_W-1:0] InMemData;
  logic [DATA_W-1:0] InPcPlus8;

  logic              Write;
  logic [4:0]        WriteRegister;
  logic [DATA_W-1:0] WriteData;
  logic              FwdValid;
  logic [4:0]        FwdReg;
  logic [DATA_W-1:0] FwdData;
  logic              AlignErr;
  logic [CNT_W-1:0]  RetireCount;

  modport master (
    output Stall, Flush, InValid, InRegWrite, InWriteReg, InResultSel,
           InLoadType, InAddrLow, InAluResult, InMemData, InPcPlus8,
    input  Write, WriteRegister, WriteData, FwdValid, FwdReg, FwdData,
           AlignErr, RetireCount
  );

  modport slave (
    input  Stall, Flush, InValid, InRegWrite, InWriteReg, InResultSel,
           InLoadType, InAddrLow, InAluResult, InMemData, InPcPlus8,
    output Write, WriteRegister, WriteData, FwdValid, FwdReg, FwdData,
           AlignErr, RetireCount
  );
endinterface

// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register with writeback select, load extraction and retire counter.
// Define WB_SUBWORD_LOAD_EN to enable LB/LBU/LH/LHU; otherwise every load is a full word.
module mem_wb_writeback #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input logic               clk,
  input logic               rst_n,
  mem_wb_writeback_if.slave bus
);

  localparam logic [1:0] SEL_MEM  = 2'd1;
  localparam logic [1:0] SEL_LINK = 2'd2;

  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] result;
  logic              misaligned;
  logic              leaving;
  logic              writes;

  logic              valid_q;
  logic              reg_write_q;
  logic              err_q;
  logic              done_q;
  logic [4:0]        write_reg_q;
  logic [DATA_W-1:0] data_q;
  logic [CNT_W-1:0]  count_q;

`ifdef WB_SUBWORD_LOAD_EN
  localparam logic [2:0] LT_LB  = 3'd1;
  localparam logic [2:0] LT_LBU = 3'd2;
  localparam logic [2:0] LT_LH  = 3'd3;
  localparam logic [2:0] LT_LHU = 3'd4;

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Little-endian lane pick; encodings 0 and 5-7 fall through as LW.
  always_comb begin
    case (bus.InAddrLow)
      2'd0:    byte_lane = bus.InMemData[7:0];
      2'd1:    byte_lane = bus.InMemData[15:8];
      2'd2:    byte_lane = bus.InMemData[23:16];
      default: byte_lane = bus.InMemData[31:24];
    endcase
    half_lane  = bus.InAddrLow[1] ? bus.InMemData[31:16] : bus.InMemData[15:0];
    load_data  = bus.InMemData;
    misaligned = (bus.InAddrLow != 2'd0);
    case (bus.InLoadType)
      LT_LB: begin
        load_data  = {{(DATA_W-8){byte_lane[7]}}, byte_lane};
        misaligned = 1'b0;
      end
      LT_LBU: begin
        load_data  = {{(DATA_W-8){1'b0}}, byte_lane};
        misaligned = 1'b0;
      end
      LT_LH: begin
        load_data  = {{(DATA_W-16){half_lane[15]}}, half_lane};
        misaligned = bus.InAddrLow[0];
      end
      LT_LHU: begin
        load_data  = {{(DATA_W-16){1'b0}}, half_lane};
        misaligned = bus.InAddrLow[0];
      end
      default: ;
    endcase
  end
`else
  logic unused_load_type;
  assign unused_load_type = ^bus.InLoadType;

  always_comb begin
    load_data  = bus.InMemData;
    misaligned = (bus.InAddrLow != 2'd0);
  end
`endif

  always_comb begin
    case (bus.InResultSel)
      SEL_MEM:  result = load_data;
      SEL_LINK: result = bus.InPcPlus8;
      default:  result = bus.InAluResult;
    endcase
  end

  assign leaving = valid_q & (~bus.Stall | bus.Flush);

  // Flush beats Stall; done marks that a held entry has already had its write slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      write_reg_q <= 5'd0;
      data_q      <= '0;
      count_q     <= '0;
    end else begin
      if (leaving) begin
        count_q <= count_q + CNT_W'(1);
      end
      if (bus.Flush) begin
        valid_q     <= 1'b0;
        reg_write_q <= 1'b0;
        err_q       <= 1'b0;
        done_q      <= 1'b0;
      end else if (!bus.Stall) begin
        valid_q     <= bus.InValid;
        reg_write_q <= bus.InRegWrite;
        err_q       <= (bus.InResultSel == SEL_MEM) & misaligned;
        done_q      <= 1'b0;
        write_reg_q <= bus.InWriteReg;
        data_q      <= result;
      end else begin
        done_q <= 1'b1;
      end
    end
  end

  assign writes            = valid_q & reg_write_q & (write_reg_q != 5'd0) & ~err_q;
  assign bus.Write         = writes & ~done_q;
  assign bus.WriteRegister = write_reg_q;
  assign bus.WriteData     = data_q;
  assign bus.FwdValid      = writes;
  assign bus.FwdReg        = write_reg_q;
  assign bus.FwdData       = data_q;
  assign bus.AlignErr      = valid_q & err_q & ~done_q;
  assign bus.RetireCount   = count_q;

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Bench for mem_wb_writeback: directed cases plus random traffic against an entry/age model.
// Follows WB_SUBWORD_LOAD_EN the same way the design does.
module tb_mem_wb_writeback;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   cyc;

  mem_wb_writeback_if #(.DATA_W(32), .CNT_W(32)) bus ();

  mem_wb_writeback #(.DATA_W(32), .CNT_W(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus copies kept by the bench for the model
  bit        s_stall, s_flush, s_valid, s_rw;
  bit [4:0]  s_rd;
  bit [1:0]  s_sel, s_al;
  bit [2:0]  s_lt;
  bit [31:0] s_alu, s_mem, s_pc8;

  // Model: the entry held by the stage and how many cycles it has been shown
  bit        m_valid, m_rw, m_err;
  bit [4:0]  m_rd;
  bit [31:0] m_data;
  int        m_age;
  bit [31:0] m_retired;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic applyStimulus(input bit stall, input bit flush, input bit valid, input bit rw,
                               input bit [4:0] rd, input bit [1:0] sel, input bit [2:0] lt,
                               input bit [1:0] al, input bit [31:0] alu, input bit [31:0] mem,
                               input bit [31:0] pc8);
    s_stall = stall; s_flush = flush; s_valid = valid; s_rw = rw; s_rd = rd;
    s_sel = sel; s_lt = lt; s_al = al; s_alu = alu; s_mem = mem; s_pc8 = pc8;
    bus.Stall = stall;       bus.Flush = flush;      bus.InValid = valid;
    bus.InRegWrite = rw;     bus.InWriteReg = rd;    bus.InResultSel = sel;
    bus.InLoadType = lt;     bus.InAddrLow = al;     bus.InAluResult = alu;
    bus.InMemData = mem;     bus.InPcPlus8 = pc8;
  endtask

  task automatic applyIdle();
    applyStimulus(0, 0, 0, 0, 5'd0, 2'd0, 3'd0, 2'd0, 32'd0, 32'd0, 32'd0);
  endtask

  function automatic bit [31:0] modelLoad(input bit [2:0] lt, input bit [1:0] al, input bit [31:0] mem);
    int unsigned b, h;
    b = (mem >> (8 * al)) & 32'hFF;
    h = (mem >> (16 * (al / 2))) & 32'hFFFF;
`ifdef WB_SUBWORD_LOAD_EN
    case (lt)
      3'd1:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd2:    return b;
      3'd3:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return h;
      default: return mem;
    endcase
`else
    return mem + 0 * (b + h + lt);
`endif
  endfunction

  function automatic bit modelMisaligned(input bit [2:0] lt, input bit [1:0] al);
`ifdef WB_SUBWORD_LOAD_EN
    if (lt == 3'd1 || lt == 3'd2) return 1'b0;
    if (lt == 3'd3 || lt == 3'd4) return (al % 2) == 1;
`endif
    return al != 0 && lt == lt;
  endfunction

  task automatic modelEdge();
    if (s_flush || !s_stall) begin
      if (m_valid) m_retired = m_retired + 1;
      m_age   = 0;
      m_valid = s_flush ? 1'b0 : s_valid;
      m_rw    = s_rw;
      m_rd    = s_rd;
      m_err   = (s_sel == 2'd1) && modelMisaligned(s_lt, s_al);
      case (s_sel)
        2'd1:    m_data = modelLoad(s_lt, s_al, s_mem);
        2'd2:    m_data = s_pc8;
        default: m_data = s_alu;
      endcase
    end else begin
      m_age++;
    end
  endtask

  task automatic modelReset();
    m_valid = 0; m_rw = 0; m_err = 0; m_rd = 0; m_data = 0; m_age = 0; m_retired = 0;
  endtask

  task automatic checkAll();
    bit writes;
    writes = m_valid && m_rw && (m_rd != 0) && !m_err;
    checkOutput("write", bus.Write, writes && m_age == 0);
    checkOutput("fwd_valid", bus.FwdValid, writes);
    checkOutput("align_err", bus.AlignErr, m_valid && m_err && m_age == 0);
    checkOutput("retire_count", bus.RetireCount, m_retired);
    if (writes) begin
      checkOutput("write_register", bus.WriteRegister, m_rd);
      checkOutput("write_data", bus.WriteData, m_data);
      checkOutput("fwd_reg", bus.FwdReg, m_rd);
      checkOutput("fwd_data", bus.FwdData, m_data);
    end
  endtask

  task automatic stepCycle();
    modelEdge();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    checkAll();
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_write"}, bus.Write, 0);
    checkOutput({tag, "_wreg"}, bus.WriteRegister, 0);
    checkOutput({tag, "_wdata"}, bus.WriteData, 0);
    checkOutput({tag, "_fwd_valid"}, bus.FwdValid, 0);
    checkOutput({tag, "_align_err"}, bus.AlignErr, 0);
    checkOutput({tag, "_count"}, bus.RetireCount, 0);
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    rst_n = 1'b0;
    applyIdle();
    modelReset();
    @(negedge clk);
    @(negedge clk);
    checkAllZero("reset");
    rst_n = 1'b1;

    // ALU op to $5, retired after the following edge
    applyStimulus(0, 0, 1, 1, 5'd5, 2'd0, 3'd0, 2'd0, 32'h0000_1234, 32'd0, 32'd0);
    stepCycle();
    checkOutput("alu_data", bus.WriteData, 32'h0000_1234);
    checkOutput("alu_write", bus.Write, 1);
    applyIdle();
    stepCycle();
    checkOutput("alu_retire", bus.RetireCount, 1);

`ifdef WB_SUBWORD_LOAD_EN
    applyStimulus(0, 0, 1, 1, 5'd6, 2'd1, 3'd1, 2'd2, 32'd0, 32'h80FF_7F01, 32'd0);
    stepCycle();
    checkOutput("lb", bus.WriteData, 32'hFFFF_FFFF);
    applyStimulus(0, 0, 1, 1, 5'd6, 2'd1, 3'd2, 2'd3, 32'd0, 32'h80FF_7F01, 32'd0);
    stepCycle();
    checkOutput("lbu", bus.WriteData, 32'h0000_0080);
    applyStimulus(0, 0, 1, 1, 5'd6, 2'd1, 3'd3, 2'd0, 32'd0, 32'h80FF_7F01, 32'd0);
    stepCycle();
    checkOutput("lh", bus.WriteData, 32'h0000_7F01);
    applyStimulus(0, 0, 1, 1, 5'd6, 2'd1, 3'd4, 2'd2, 32'd0, 32'h80FF_7F01, 32'd0);
    stepCycle();
    checkOutput("lhu", bus.WriteData, 32'h0000_80FF);
`else
    applyStimulus(0, 0, 1, 1, 5'd6, 2'd1, 3'd1, 2'd0, 32'd0, 32'h80FF_7F01, 32'd0);
    stepCycle();
    checkOutput("lb_as_lw", bus.WriteData, 32'h80FF_7F01);
    checkOutput("lb_as_lw_write", bus.Write, 1);
`endif

    // Register $0 and a link write
    applyStimulus(0, 0, 1, 1, 5'd0, 2'd0, 3'd0, 2'd0, 32'hDEAD_BEEF, 32'd0, 32'd0);
    stepCycle();
    checkOutput("r0_write", bus.Write, 0);
    checkOutput("r0_fwd", bus.FwdValid, 0);
    applyStimulus(0, 0, 1, 1, 5'd31, 2'd2, 3'd0, 2'd0, 32'd0, 32'd0, 32'h0040_0010);
    stepCycle();
    checkOutput("jal_write", bus.Write, 1);
    checkOutput("jal_data", bus.WriteData, 32'h0040_0010);

    // Write to $8 held for three stall edges
    applyStimulus(0, 0, 1, 1, 5'd8, 2'd0, 3'd0, 2'd0, 32'h0000_0808, 32'd0, 32'd0);
    stepCycle();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 1, 1, 5'd9, 2'd0, 3'd0, 2'd0, $urandom, 32'd0, 32'd0);
      stepCycle();
      checkOutput("stall_write", bus.Write, 0);
      checkOutput("stall_fwd", bus.FwdValid, 1);
    end
    applyIdle();
    stepCycle();
    applyIdle();
    stepCycle();

    // Stall and Flush together capture a bubble
    applyStimulus(1, 1, 1, 1, 5'd7, 2'd0, 3'd0, 2'd0, 32'h7777_7777, 32'd0, 32'd0);
    stepCycle();
    checkOutput("flush_write", bus.Write, 0);

    // Misaligned LW to $4
    applyStimulus(0, 0, 1, 1, 5'd4, 2'd1, 3'd0, 2'd1, 32'd0, 32'h1111_2222, 32'd0);
    stepCycle();
    checkOutput("misalign_pulse", bus.AlignErr, 1);
    checkOutput("misalign_write", bus.Write, 0);
    applyIdle();
    stepCycle();
    checkOutput("misalign_pulse_end", bus.AlignErr, 0);

    // Reset asserted while a write is held by Stall
    applyStimulus(0, 0, 1, 1, 5'd8, 2'd0, 3'd0, 2'd0, 32'h0000_0ABC, 32'd0, 32'd0);
    stepCycle();
    applyStimulus(1, 0, 0, 0, 5'd0, 2'd0, 3'd0, 2'd0, 32'd0, 32'd0, 32'd0);
    stepCycle();
    #2 rst_n = 1'b0;
    #1 checkAllZero("mid_reset");
    modelReset();
    @(negedge clk);
    applyIdle();
    rst_n = 1'b1;
    checkAllZero("post_reset");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom % 100) < 25, ($urandom % 100) < 8, ($urandom % 100) < 80,
                    ($urandom % 100) < 85, 5'($urandom_range(0, 31) % (i % 2 ? 8 : 32)),
                    2'($urandom % 4), 3'($urandom % 8), 2'($urandom % 4),
                    $urandom, $urandom, $urandom);
      stepCycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_wb_writeback.md
Name: mem_wb_writeback

Overview:
- MEM/WB pipeline stage of the MIPS datapath.
- Captures MEM-stage results, selects the writeback value (ALU result, load data with sub-word extraction, or link address) and registers it.
- Drives the register file write port: Write, WriteRegister, WriteData.
- Also provides a forwarding tap, an alignment-error flag and a retired-instruction counter.

Parameters:
- DATA_W, 32, datapath width.
- CNT_W, 32, width of RetireCount.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Stall  in  1  hold the stage contents.
- Flush  in  1  squash the incoming instruction (insert bubble).
- InValid  in  1  MEM stage holds a real instruction.
- InRegWrite  in  1  instruction writes a register.
- InWriteReg  in  5  destination register number.
- InResultSel  in  2  0=ALU, 1=memory load, 2=link (PC+8), 3=treated as ALU.
- InLoadType  in  3  0=LW, 1=LB, 2=LBU, 3=LH, 4=LHU, 5-7=treated as LW.
- InAddrLow  in  2  load address bits [1:0].
- InAluResult  in  DATA_W  ALU result.
- InMemData  in  DATA_W  word read from data memory.
- InPcPlus8  in  DATA_W  link address.
- Write  out  1  register file write enable.
- WriteRegister  out  5  register file write address.
- WriteData  out  DATA_W  register file write data.
- FwdValid  out  1  stage holds a value usable for forwarding.
- FwdReg  out  5  forwarded register number.
- FwdData  out  DATA_W  forwarded value; equals WriteData.
- AlignErr  out  1  one-cycle pulse: misaligned load retired.
- RetireCount  out  CNT_W  count of valid instructions retired.

Behaviour:
- Reset (rst_n=0, asynchronous): every output and internal register goes to 0, including the valid, done and error flags and RetireCount.
- Capture: on each rising edge with Stall=0, the stage register loads the incoming fields. The result is computed combinationally from the inputs and stored registered, so WriteData is 1 cycle after the inputs.
- Flush has priority over Stall. With Flush=1, the captured valid bit is 0 and the remaining fields are don't-care, but must not cause Write.
- Stall=1 and Flush=0: stage contents are held unchanged.
- Result select:
  - ALU: InAluResult.
  - LINK: InPcPlus8.
  - MEM: extracted load data, as below.
- Load extraction uses little-endian lanes: lane n is bits [8n+7:8n].
  - LB/LBU select byte lane InAddrLow; LB sign-extends, LBU zero-extends.
  - LH/LHU select half InAddrLow[1] (0 gives [15:0], 1 gives [31:16]); LH sign-extends, LHU zero-extends.
  - LW uses the whole word.
- Alignment error: a MEM-select load is misaligned if it is LW with InAddrLow!=0, or LH/LHU with InAddrLow[0]=1.
  - The captured entry is marked err.
  - Write is suppressed, FwdValid=0, AlignErr=1 for the single cycle the entry is first presented, and RetireCount still increments.
- Write = valid & RegWrite & (WriteRegister!=0) & !err & !done. Register $0 is never written.
- done flag:
  - Set on the first clock edge where the entry is held by Stall.
  - Cleared whenever a new entry is captured.
  - Effect: a stalled entry asserts Write exactly once.
- FwdValid = valid & RegWrite & (WriteRegister!=0) & !err. It stays asserted for the whole stall, independent of done.
- RetireCount:
  - Increments by 1 on each rising edge where the stage holds a valid entry that is leaving (Stall=0 or Flush=1), counted once per entry.
  - Wraps modulo 2^CNT_W.
- AlignErr: asserts only in the first cycle of an erroneous entry, never repeated during a stall.
- Reset mid-stall: the entry is discarded, no write occurs, and the counter returns to 0.

Optional Feature:
- Macro WB_SUBWORD_LOAD_EN.
- Defined: LB/LBU/LH/LHU extraction and half-word alignment checking as specified.
- Undefined:
  - InLoadType is ignored and every MEM-select load is treated as LW (full word; misaligned only if InAddrLow!=0).
  - InLoadType and the sub-word extraction logic are unused.

Test Plan:
- Reset then ALU op: InValid=1, InRegWrite=1, InWriteReg=5, InResultSel=0, InAluResult=0x0000_1234 -> next cycle Write=1, WriteRegister=5, WriteData=0x0000_1234, RetireCount=1 after the following edge.
- Sub-word loads (macro defined): InMemData=0x80FF_7F01.
  - LB, InAddrLow=2 -> WriteData=0xFFFF_FFFF.
  - LBU, InAddrLow=3 -> 0x0000_0080.
  - LH, InAddrLow=0 -> 0x0000_7F01.
  - LHU, InAddrLow=2 -> 0x0000_80FF.
- $0 and link: InWriteReg=0 with ALU op -> Write=0, FwdValid=0. JAL with InWriteReg=31, InPcPlus8=0x0040_0010 -> Write=1, WriteData=0x0040_0010.
- Stall for 3 cycles on a write to $8 -> Write high only in the first cycle, FwdValid high all 4 cycles, RetireCount +1 once.
- Stall=1 and Flush=1 together with a valid input -> bubble captured, Write=0, no counter change. Assert rst_n=0 mid-stall -> all outputs 0 immediately, no write.
- Misaligned LW, InAddrLow=1, InWriteReg=4 -> AlignErr pulses 1 cycle, Write=0, RetireCount increments. With the macro undefined, LB at InAddrLow=0 -> behaves as LW, full word written.
